// File: rtl/motion_pkg.sv
// Shared types and constants for the player motion controller.
package motion_pkg;

  localparam int unsigned POS_W = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_WALK = 2'd2
  } state_e;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;

endpackage

// File: rtl/key_to_dir.sv
// Combinational decode of a USB HID keycode into a walk direction.
module key_to_dir
  import motion_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       valid,
  output dir_e       dir
);

  // Map W/D/S/A onto up/right/down/left; anything else is "no key".
  always_comb begin
    valid = 1'b1;
    dir   = DIR_UP;
    unique case (keycode)
      KEY_W:   dir = DIR_UP;
      KEY_D:   dir = DIR_RIGHT;
      KEY_S:   dir = DIR_DOWN;
      KEY_A:   dir = DIR_LEFT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Tile-stepped player movement: turn in place, then walk one tile per
// TILE_PX frame ticks. Optional feature macro: MOTION_BOUNDS_EN keeps
// walks inside [0,MAP_MAX_X]x[0,MAP_MAX_Y]; otherwise positions wrap.
module player_motion_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned  TILE_PX     = 16,
  parameter int unsigned  TURN_FRAMES = 4,
  parameter logic [9:0]   MAP_MAX_X   = 10'd624,
  parameter logic [9:0]   MAP_MAX_Y   = 10'd464
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic [7:0]       keycode,
  output logic             Character_Moving,
  output logic [1:0]       Direction,
  output logic [POS_W-1:0] MapX,
  output logic [POS_W-1:0] MapY,
  output logic             Anim_Tick
);

  localparam int unsigned STEP_W = $clog2(TILE_PX);
  localparam int unsigned TURN_W = $clog2(TURN_FRAMES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TILE_PX - 1);
  localparam logic [STEP_W-1:0] STEP_HALF = STEP_W'(TILE_PX / 2 - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_FRAMES - 1);

  state_e            state_q, state_nxt;
  dir_e              dir_q, dir_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;
  logic [POS_W-1:0]  x_nxt, y_nxt, x_mv, y_mv;
  logic              moving_nxt, anim_nxt;
  logic              key_valid;
  dir_e              key_dir;
  logic              in_bounds;
  logic              same_key, new_key;

  key_to_dir u_key_to_dir (
    .keycode (keycode),
    .valid   (key_valid),
    .dir     (key_dir)
  );

  assign Direction = dir_q;
  assign same_key  = key_valid && (key_dir == dir_q);
  assign new_key   = key_valid && (key_dir != dir_q);

  // Position after a one-pixel step in the current facing.
  always_comb begin
    x_mv = MapX;
    y_mv = MapY;
    unique case (dir_q)
      DIR_UP:    y_mv = MapY - POS_W'(1);
      DIR_RIGHT: x_mv = MapX + POS_W'(1);
      DIR_DOWN:  y_mv = MapY + POS_W'(1);
      DIR_LEFT:  x_mv = MapX - POS_W'(1);
      default:   x_mv = MapX;
    endcase
  end

`ifdef MOTION_BOUNDS_EN
  logic [POS_W-1:0] base_x, base_y;

  // The next tile is measured from where this tick leaves the player.
  always_comb begin
    base_x    = (state_q == ST_WALK) ? x_mv : MapX;
    base_y    = (state_q == ST_WALK) ? y_mv : MapY;
    in_bounds = 1'b1;
    unique case (dir_q)
      DIR_UP:    in_bounds = ({1'b0, base_y} >= 11'(TILE_PX));
      DIR_RIGHT: in_bounds = (({1'b0, base_x} + 11'(TILE_PX)) <= {1'b0, MAP_MAX_X});
      DIR_DOWN:  in_bounds = (({1'b0, base_y} + 11'(TILE_PX)) <= {1'b0, MAP_MAX_Y});
      DIR_LEFT:  in_bounds = ({1'b0, base_x} >= 11'(TILE_PX));
      default:   in_bounds = 1'b1;
    endcase
  end
`else
  logic unused_bounds;
  assign unused_bounds = ^{MAP_MAX_X, MAP_MAX_Y};
  assign in_bounds     = 1'b1;
`endif

  // State and output register; reset wins over a coincident frame tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      dir_q            <= DIR_UP;
      step_cnt         <= '0;
      turn_cnt         <= '0;
      MapX             <= '0;
      MapY             <= '0;
      Character_Moving <= 1'b0;
      Anim_Tick        <= 1'b0;
    end else begin
      state_q          <= state_nxt;
      dir_q            <= dir_nxt;
      step_cnt         <= step_nxt;
      turn_cnt         <= turn_nxt;
      MapX             <= x_nxt;
      MapY             <= y_nxt;
      Character_Moving <= moving_nxt;
      Anim_Tick        <= anim_nxt;
    end
  end

  // Next-state and next-output logic; only frame ticks advance anything.
  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    step_nxt  = step_cnt;
    turn_nxt  = turn_cnt;
    x_nxt     = MapX;
    y_nxt     = MapY;
    anim_nxt  = 1'b0;
    if (frame_start) begin
      unique case (state_q)
        ST_IDLE: begin
          if (same_key) begin
            if (in_bounds) state_nxt = ST_WALK;
            step_nxt = '0;
          end else if (new_key) begin
            dir_nxt   = key_dir;
            state_nxt = ST_TURN;
            turn_nxt  = '0;
          end
        end
        ST_TURN: begin
          if (turn_cnt == TURN_LAST) begin
            turn_nxt  = '0;
            step_nxt  = '0;
            state_nxt = (same_key && in_bounds) ? ST_WALK : ST_IDLE;
          end else if (new_key) begin
            dir_nxt  = key_dir;
            turn_nxt = '0;
          end else begin
            turn_nxt = turn_cnt + TURN_W'(1);
          end
        end
        ST_WALK: begin
          x_nxt    = x_mv;
          y_nxt    = y_mv;
          step_nxt = step_cnt + STEP_W'(1);
          anim_nxt = (step_cnt == STEP_HALF) || (step_cnt == STEP_LAST);
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (same_key && in_bounds) begin
              state_nxt = ST_WALK;
            end else if (new_key) begin
              dir_nxt   = key_dir;
              state_nxt = ST_TURN;
              turn_nxt  = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    moving_nxt = (state_nxt == ST_WALK);
  end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 SHALL have parameter TILE_PX, default 16, pixels per tile step (power of two, 4..32).
REQ-002 SHALL have parameter TURN_FRAMES, default 4, frames spent turning in place before walking.
REQ-003 SHALL have parameter MAP_MAX_X, default 10'd624, largest legal MapX (tile-aligned).
REQ-004 SHALL have parameter MAP_MAX_Y, default 10'd464, largest legal MapY (tile-aligned).
REQ-005 SHALL have port Clk  input  1  system clock; the single clock.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at vertical-blank start; the frame tick.
REQ-008 SHALL have port keycode  input  8  USB HID keycode, sampled only on frame ticks.
REQ-009 SHALL have port Character_Moving  output  1  high while walking.
REQ-010 SHALL have port Direction  output  2  facing: 0 up, 1 right, 2 down, 3 left.
REQ-011 SHALL have port MapX  output  10  world X offset of the player.
REQ-012 SHALL have port MapY  output  10  world Y offset of the player.
REQ-013 SHALL have port Anim_Tick  output  1  one-cycle pulse telling the sprite stage to advance its walk frame.

Function
REQ-014 SHALL decode keycode 0x1A/0x07/0x16/0x04 (W/D/S/A) to direction 0/1/2/3; every other value means "no key".
REQ-015 SHALL change state, counters or outputs only in cycles where frame_start=1; all outputs registered, valid the cycle after the tick.
REQ-016 SHALL implement the FSM states IDLE, TURN, WALK.
REQ-017 IDLE: no key -> stay; key equal to Direction -> WALK; key different -> Direction<=key, TURN, turn_cnt<=0.
REQ-018 TURN: turn_cnt increments per tick; at TURN_FRAMES-1, key equal to Direction -> WALK, else IDLE; a different key mid-turn updates Direction and restarts turn_cnt.
REQ-019 WALK: each tick move MapX/MapY by 1 px (up: Y-1, right: X+1, down: Y+1, left: X-1), step_cnt increments; keycode ignored until step_cnt=TILE_PX-1.
REQ-020 At tile end (step_cnt=TILE_PX-1, same tick as last pixel move): same key -> continue WALK, step_cnt<=0; different key -> TURN; no key -> IDLE.
REQ-021 Character_Moving SHALL be 1 exactly in WALK.
REQ-022 Anim_Tick SHALL pulse on the tick where step_cnt reaches TILE_PX/2-1 and TILE_PX-1 (two pulses per tile).
REQ-023 Positions SHALL stay tile-aligned in IDLE/TURN (low log2(TILE_PX) bits zero).

Reset
REQ-024 Reset SHALL take priority over frame_start in the same cycle.
REQ-025 Reset values: state IDLE, Direction 0, Character_Moving 0, Anim_Tick 0, MapX 0, MapY 0, step_cnt 0, turn_cnt 0.
REQ-026 Reset mid-WALK SHALL abandon the partial tile; no further pixel moves.

Configuration
REQ-027 With MOTION_BOUNDS_EN defined: a WALK entry whose target tile lies outside [0,MAP_MAX_X]x[0,MAP_MAX_Y] SHALL not occur; the block remains/returns to IDLE with Direction updated and Character_Moving 0.
REQ-028 Without MOTION_BOUNDS_EN: no bounds check; MapX/MapY wrap modulo 1024.

Structure
REQ-029 Package motion_pkg SHALL hold the direction enum, FSM state enum, and the four keycode constants.
REQ-030 Sub-module key_to_dir (keycode -> valid + direction, combinational) SHALL be instantiated once.

Verification
REQ-031 Reset, hold keycode 0x1A 20 ticks -> Direction 0, WALK from first tick, no move while MapY=0 (bounds on); with bounds off MapY=1023 after first move tick.
REQ-032 From MapX=0 IDLE, Direction 0, hold 0x07 -> 4 ticks TURN with Moving 0, then 16 ticks WALK, MapX=16, Anim_Tick pulses at step 7 and 15.
REQ-033 Release key at step 5 of a tile -> walk continues to step 15, then IDLE, MapX tile-aligned.
REQ-034 Keycode 0x16 held but frame_start held 0 for 100 cycles -> no output change.
REQ-035 Assert Reset together with frame_start at step 9 -> next cycle IDLE, MapX=MapY=0, Moving 0.
REQ-036 Unknown keycode 0x2C in IDLE -> stays IDLE, Direction unchanged.
